// File: rtl/vga_pkg.sv
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared widths and state encoding for the VGA grid write
//                arbiter and its round-robin picker.
//  Contents    : GRID_W, COLOR_W, GRID_CELLS, state_e (IDLE/HOLD/CLEAR)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

   localparam int GRID_W     = 8;
   localparam int COLOR_W    = 8;
   localparam int GRID_CELLS = 256;

   // CLEAR is only ever entered when VGA_GRID_CLEAR_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_CLEAR = 2'd2
   } state_e;

endpackage : vga_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin pick. Searches req from
//                index ptr upward, wrapping modulo N_REQ, and returns a
//                one-hot grant for the first set bit (all zeros if none).
//  Ports       : req [N_REQ-1:0]  in   request vector
//                ptr [PTR_W-1:0]  in   highest-priority index (< N_REQ)
//                gnt [N_REQ-1:0]  out  one-hot grant
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N_REQ = 3,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt
);

   int   w_idx;
   logic w_found;

   always_comb begin
      gnt     = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = int'(ptr) + k;
         if (w_idx >= N_REQ) begin
            w_idx = w_idx - N_REQ;
         end
         // Constant-indexed inner loop keeps every bit select static.
         for (int j = 0; j < N_REQ; j++) begin
            if (!w_found && (j == w_idx) && req[j]) begin
               gnt[j]  = 1'b1;
               w_found = 1'b1;
            end
         end
      end
   end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/vga_grid_arbiter.sv
// ============================================================================
//  Module      : vga_grid_arbiter
//  Description : Shares the single VGA grid write port between N_REQ
//                requesters with round-robin arbitration and valid/ready
//                handshakes. Each accepted write is held for HOLD_CYCLES clk
//                cycles so the slower VGA domain samples it safely.
//  Optional    : VGA_GRID_CLEAR_EN adds clr_req/clr_done and a CLEAR state
//                that walks all 256 cells with CLEAR_COLOR.
//  Ports       : clk, rst                  clock, sync active-high reset
//                req_valid/req_ready       per-requester handshake
//                req_pos/req_color         packed 8-bit fields per requester
//                grant                     one-hot owner of held write
//                Grid_Position/Color       registered write to vga_out
//                grid_we                   live-write strobe
//                busy                      not IDLE
//                clr_req/clr_done          (optional) clear request/done
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_grid_arbiter
   import vga_pkg::*;
#(
   parameter int                 N_REQ       = 3,
   parameter int                 HOLD_CYCLES = 4,
   parameter logic [COLOR_W-1:0] CLEAR_COLOR = 8'h00
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [GRID_W*N_REQ-1:0]   req_pos,
   input  logic [COLOR_W*N_REQ-1:0]  req_color,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          grant,
   output logic [GRID_W-1:0]         Grid_Position,
   output logic [COLOR_W-1:0]        Color,
   output logic                      grid_we,
   output logic                      busy
`ifdef VGA_GRID_CLEAR_EN
   ,
   input  logic                      clr_req,
   output logic                      clr_done
`endif
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  c_hold_last = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [GRID_W-1:0] c_last_cell = GRID_W'(GRID_CELLS - 1);

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [GRID_W-1:0]    pos_q, pos_d;
   logic [COLOR_W-1:0]   color_q, color_d;
   logic                 we_q, we_d;
   logic [N_REQ-1:0]     grant_q, grant_d;

   logic [N_REQ-1:0]     w_pick;
   logic                 w_xfer;
   logic [GRID_W-1:0]    w_sel_pos;
   logic [COLOR_W-1:0]   w_sel_color;
   logic [PTR_W-1:0]     w_nxt_ptr;
   logic                 w_block;

`ifdef VGA_GRID_CLEAR_EN
   logic clr_pend_q, clr_pend_d;
   logic clr_rearm_q, clr_rearm_d;
   logic clr_done_q, clr_done_d;
   logic w_clr_pend;

   // A request arriving this very cycle already wins over the requesters.
   assign w_clr_pend = clr_pend_q | clr_req;
   assign w_block    = rst | w_clr_pend;
   assign clr_done   = clr_done_q;
`else
   assign w_block    = rst;
`endif

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (w_pick)
   );

   assign req_ready = (state_q == ST_IDLE && !w_block) ? w_pick : '0;
   assign w_xfer    = |(req_valid & req_ready);

   always_comb begin
      w_sel_pos   = '0;
      w_sel_color = '0;
      w_nxt_ptr   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            w_sel_pos   = req_pos[i*GRID_W +: GRID_W];
            w_sel_color = req_color[i*COLOR_W +: COLOR_W];
            w_nxt_ptr   = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      color_d = color_q;
      we_d    = we_q;
      grant_d = grant_q;
`ifdef VGA_GRID_CLEAR_EN
      clr_pend_d  = clr_pend_q | clr_req;
      clr_rearm_d = clr_rearm_q;
      clr_done_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef VGA_GRID_CLEAR_EN
            if (w_clr_pend) begin
               // First cell is presented on the entry edge, like a write.
               state_d = ST_CLEAR;
               pos_d   = '0;
               color_d = CLEAR_COLOR;
               we_d    = 1'b1;
               grant_d = '0;
               cnt_d   = c_hold_last;
            end else
`endif
            if (w_xfer) begin
               state_d = ST_HOLD;
               pos_d   = w_sel_pos;
               color_d = w_sel_color;
               we_d    = 1'b1;
               grant_d = req_ready;
               cnt_d   = c_hold_last;
               ptr_d   = w_nxt_ptr;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               we_d    = 1'b0;
               grant_d = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef VGA_GRID_CLEAR_EN
         ST_CLEAR: begin
            // clr_pend stays set for the walk; a new request during the
            // walk is remembered separately so it re-arms on completion.
            if (clr_req) begin
               clr_rearm_d = 1'b1;
            end
            if (cnt_q == '0) begin
               if (pos_q == c_last_cell) begin
                  state_d     = ST_IDLE;
                  we_d        = 1'b0;
                  clr_done_d  = 1'b1;
                  clr_pend_d  = clr_rearm_q | clr_req;
                  clr_rearm_d = 1'b0;
               end else begin
                  pos_d = pos_q + 1'b1;
                  cnt_d = c_hold_last;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            we_d    = 1'b0;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         pos_q   <= '0;
         color_q <= '0;
         we_q    <= 1'b0;
         grant_q <= '0;
`ifdef VGA_GRID_CLEAR_EN
         clr_pend_q  <= 1'b0;
         clr_rearm_q <= 1'b0;
         clr_done_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         color_q <= color_d;
         we_q    <= we_d;
         grant_q <= grant_d;
`ifdef VGA_GRID_CLEAR_EN
         clr_pend_q  <= clr_pend_d;
         clr_rearm_q <= clr_rearm_d;
         clr_done_q  <= clr_done_d;
`endif
      end
   end

   assign grant         = grant_q;
   assign Grid_Position = pos_q;
   assign Color         = color_q;
   assign grid_we       = we_q;
   assign busy          = (state_q != ST_IDLE);

endmodule : vga_grid_arbiter

`default_nettype wire

// File: tb/tb_vga_grid_arbiter.sv
// ============================================================================
//  Module      : tb_vga_grid_arbiter
//  Description : Directed self-checking bench for vga_grid_arbiter with
//                N_REQ=3, HOLD_CYCLES=4. Covers reset, single write,
//                round-robin rotation, withdraw, back-to-back writes and,
//                when VGA_GRID_CLEAR_EN is defined, the clear sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_grid_arbiter;

   localparam int         N_REQ       = 3;
   localparam int         HOLD_CYCLES = 4;
   localparam logic [7:0] CLEAR_COLOR = 8'h00;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [23:0] req_pos;
   logic [23:0] req_color;
   logic [2:0]  req_ready;
   logic [2:0]  grant;
   logic [7:0]  Grid_Position;
   logic [7:0]  Color;
   logic        grid_we;
   logic        busy;
`ifdef VGA_GRID_CLEAR_EN
   logic        clr_req;
   logic        clr_done;
`endif

   int n_checks;
   int n_errors;

   vga_grid_arbiter #(
      .N_REQ       (N_REQ),
      .HOLD_CYCLES (HOLD_CYCLES),
      .CLEAR_COLOR (CLEAR_COLOR)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_pos       (req_pos),
      .req_color     (req_color),
      .req_ready     (req_ready),
      .grant         (grant),
      .Grid_Position (Grid_Position),
      .Color         (Color),
      .grid_we       (grid_we),
      .busy          (busy)
`ifdef VGA_GRID_CLEAR_EN
      ,
      .clr_req       (clr_req),
      .clr_done      (clr_done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0;
      req_pos   = '0;
      req_color = '0;
`ifdef VGA_GRID_CLEAR_EN
      clr_req   = 1'b0;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      n_checks++;
      if ({grid_we, busy, grant, req_ready} !== 8'h00 || Grid_Position !== 8'h00 || Color !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_state: we=%b busy=%b grant=%b ready=%b pos=%h col=%h, required all zero",
                  grid_we, busy, grant, req_ready, Grid_Position, Color);
      end
      rst = 1'b0;
      req_valid = 3'b001;
      req_pos[7:0] = 8'h12;
      req_color[7:0] = 8'h5A;
      #1;
      n_checks++;
      if (req_ready !== 3'b001) begin
         n_errors++;
         $display("FAIL reset_req0_ready: got %b required 001", req_ready);
      end
      tick();
      n_checks++;
      if (grid_we !== 1'b1 || Grid_Position !== 8'h12 || grant !== 3'b001 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_pre_write: we=%b pos=%h grant=%b busy=%b, required 1 12 001 1",
                  grid_we, Grid_Position, grant, busy);
      end
      req_valid = '0;
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (grid_we !== 1'b0 || Grid_Position !== 8'h00 || Color !== 8'h00 || grant !== 3'b000 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid_hold: we=%b pos=%h col=%h grant=%b busy=%b, required all zero",
                  grid_we, Grid_Position, Color, grant, busy);
      end
      rst = 1'b0;
      req_valid = 3'b111;
      #1;
      n_checks++;
      if (req_ready !== 3'b001) begin
         n_errors++;
         $display("FAIL reset_ptr: ready got %b required 001", req_ready);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_single_write();
      clear_inputs();
      req_valid = 3'b010;
      req_pos[15:8] = 8'h3C;
      req_color[15:8] = 8'hE0;
      #1;
      n_checks++;
      if (req_ready !== 3'b010) begin
         n_errors++;
         $display("FAIL single_ready: got %b required 010", req_ready);
      end
      tick();
      n_checks++;
      if (grid_we !== 1'b1 || Grid_Position !== 8'h3C || Color !== 8'hE0 || grant !== 3'b010 || req_ready !== 3'b000) begin
         n_errors++;
         $display("FAIL single_start: we=%b pos=%h col=%h grant=%b ready=%b, required 1 3c e0 010 000",
                  grid_we, Grid_Position, Color, grant, req_ready);
      end
      req_valid = '0;
      for (int c = 1; c < HOLD_CYCLES; c++) begin
         tick();
         n_checks++;
         if (grid_we !== 1'b1 || Grid_Position !== 8'h3C || grant !== 3'b010) begin
            n_errors++;
            $display("FAIL single_hold_%0d: we=%b pos=%h grant=%b, required 1 3c 010", c, grid_we, Grid_Position, grant);
         end
      end
      tick();
      n_checks++;
      if (grid_we !== 1'b0 || grant !== 3'b000 || busy !== 1'b0 || Grid_Position !== 8'h3C || Color !== 8'hE0) begin
         n_errors++;
         $display("FAIL single_end: we=%b grant=%b busy=%b pos=%h col=%h, required 0 000 0 3c e0",
                  grid_we, grant, busy, Grid_Position, Color);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_g;
      logic [7:0] exp_p;
      do_reset();
      clear_inputs();
      req_pos   = {8'hA2, 8'hA1, 8'hA0};
      req_color = {8'h33, 8'h22, 8'h11};
      req_valid = 3'b111;
      for (int w = 0; w < 9; w++) begin
         exp_g = 3'b001 << (w % 3);
         exp_p = 8'hA0 + 8'(w % 3);
         tick();
         n_checks++;
         if (grid_we !== 1'b1 || grant !== exp_g || Grid_Position !== exp_p) begin
            n_errors++;
            $display("FAIL rr_write_%0d: we=%b grant=%b pos=%h, required 1 %b %h", w, grid_we, grant, Grid_Position, exp_g, exp_p);
         end
         repeat (HOLD_CYCLES - 1) tick();
         n_checks++;
         if (grid_we !== 1'b1) begin
            n_errors++;
            $display("FAIL rr_hold_%0d: we=%b required 1", w, grid_we);
         end
         tick();
         n_checks++;
         if (grid_we !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rr_gap_%0d: we=%b busy=%b required 0 0", w, grid_we, busy);
         end
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_withdraw();
      int bad;
      do_reset();
      clear_inputs();
      req_pos   = {8'h77, 8'h00, 8'h44};
      req_color = {8'h88, 8'h00, 8'h55};
      req_valid = 3'b001;
      tick();
      n_checks++;
      if (grant !== 3'b001 || Grid_Position !== 8'h44) begin
         n_errors++;
         $display("FAIL wd_req0: grant=%b pos=%h required 001 44", grant, Grid_Position);
      end
      req_valid = 3'b100;
      bad = 0;
      tick();
      if (req_ready !== 3'b000) bad++;
      tick();
      if (req_ready !== 3'b000) bad++;
      req_valid = 3'b000;
      tick();
      if (grid_we !== 1'b1) bad++;
      tick();
      if (grid_we !== 1'b0) bad++;
      repeat (3) begin
         tick();
         if (grid_we !== 1'b0 || grant !== 3'b000 || req_ready !== 3'b000) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL wd_no_req2: %0d bad cycles, required 0", bad);
      end
      n_checks++;
      if (Grid_Position !== 8'h44 || Color !== 8'h55) begin
         n_errors++;
         $display("FAIL wd_last_data: pos=%h col=%h required 44 55", Grid_Position, Color);
      end
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      req_valid = 3'b001;
      req_pos[7:0] = 8'h00;
      req_color[7:0] = 8'hC0;
      for (int w = 0; w < 4; w++) begin
         tick();
         n_checks++;
         if (grid_we !== 1'b1 || Grid_Position !== 8'(w) || grant !== 3'b001) begin
            n_errors++;
            $display("FAIL b2b_start_%0d: we=%b pos=%h grant=%b required 1 %h 001", w, grid_we, Grid_Position, grant, 8'(w));
         end
         // Next data presented during the hold must be taken only at the next transfer.
         req_pos[7:0] = 8'(w + 1);
         if (w == 3) req_valid = '0;
         repeat (HOLD_CYCLES - 1) tick();
         n_checks++;
         if (grid_we !== 1'b1 || Grid_Position !== 8'(w)) begin
            n_errors++;
            $display("FAIL b2b_hold_%0d: we=%b pos=%h required 1 %h", w, grid_we, Grid_Position, 8'(w));
         end
         tick();
         n_checks++;
         if (grid_we !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_gap_%0d: we=%b required 0", w, grid_we);
         end
      end
      tick();
      n_checks++;
      if (grid_we !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_idle: we=%b busy=%b required 0 0", grid_we, busy);
      end
   endtask

`ifdef VGA_GRID_CLEAR_EN
   task automatic test_clear();
      int bad;
      do_reset();
      clear_inputs();
      req_valid = 3'b010;
      req_pos[15:8] = 8'h5D;
      req_color[15:8] = 8'h1F;
      clr_req = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 3'b000) begin
         n_errors++;
         $display("FAIL clr_ready_blocked: got %b required 000", req_ready);
      end
      tick();
      clr_req = 1'b0;
      n_checks++;
      if (grid_we !== 1'b1 || Grid_Position !== 8'h00 || Color !== CLEAR_COLOR || grant !== 3'b000) begin
         n_errors++;
         $display("FAIL clr_start: we=%b pos=%h col=%h grant=%b required 1 00 %h 000",
                  grid_we, Grid_Position, Color, grant, CLEAR_COLOR);
      end
      bad = 0;
      for (int c = 1; c < 256 * HOLD_CYCLES; c++) begin
         tick();
         if (grid_we !== 1'b1 || req_ready !== 3'b000 || clr_done !== 1'b0 || Grid_Position !== 8'(c / HOLD_CYCLES)) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL clr_walk: %0d bad cycles required 0", bad);
      end
      n_checks++;
      if (Grid_Position !== 8'hFF || Color !== CLEAR_COLOR) begin
         n_errors++;
         $display("FAIL clr_last: pos=%h col=%h required ff %h", Grid_Position, Color, CLEAR_COLOR);
      end
      tick();
      n_checks++;
      if (grid_we !== 1'b0 || clr_done !== 1'b1 || req_ready !== 3'b010) begin
         n_errors++;
         $display("FAIL clr_done: we=%b done=%b ready=%b required 0 1 010", grid_we, clr_done, req_ready);
      end
      tick();
      n_checks++;
      if (clr_done !== 1'b0 || grant !== 3'b010 || Grid_Position !== 8'h5D || Color !== 8'h1F) begin
         n_errors++;
         $display("FAIL clr_then_req1: done=%b grant=%b pos=%h col=%h required 0 010 5d 1f",
                  clr_done, grant, Grid_Position, Color);
      end
      req_valid = '0;
      repeat (HOLD_CYCLES + 1) tick();
   endtask
`endif

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single_write();
      test_round_robin();
      test_withdraw();
      test_back_to_back();
`ifdef VGA_GRID_CLEAR_EN
      test_clear();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_vga_grid_arbiter

`default_nettype wire
